// File: rtl/alu_shift_if.sv
// Request/response bundle between the execute-stage control and the iterative shifter.
interface alu_shift_if #(parameter int WIDTH = 32);
  logic             start;
  logic [4:0]       alu_code;
  logic [WIDTH-1:0] operand;
  logic [4:0]       shamt;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, alu_code, operand, shamt, flush,
                  input  busy, done, result);
  modport slave  (input  start, alu_code, operand, shamt, flush,
                  output busy, done, result);
endinterface

// File: rtl/alu_shift_unit.sv
// Iterative SLL/SRL/SRA shifter: STEP positions per cycle, busy/done handshake.
module alu_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_shift_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] STEP_C = 5'(STEP);
  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, result_q, shifted, fill_mask;
  logic [4:0]       cnt_q, s;
  logic [1:0]       op_q, op_dec;
  logic             sign_q, done_q, done_d;
  logic             legal, accept, last;

  always_comb begin
    op_dec = OP_SLL;
    legal  = 1'b1;
    case (bus.alu_code)
      5'b10000: op_dec = OP_SLL;
      5'b10001: op_dec = OP_SRL;
      5'b10010: op_dec = OP_SRA;
      default:  legal  = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && bus.start && legal && !bus.flush;

  // Final step shifts only what remains, so the last cycle may move fewer than STEP bits.
  always_comb begin
    s         = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    last      = (cnt_q <= STEP_C);
    fill_mask = ~({WIDTH{1'b1}} >> s);
    case (op_q)
      OP_SLL:  shifted = data_q << s;
      OP_SRL:  shifted = data_q >> s;
      default: shifted = (data_q >> s) | (fill_mask & {WIDTH{sign_q}});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    bus.busy = (state_q == SHIFT);
  end

  assign done_d = (state_q == SHIFT) && last && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= done_d;
      if (done_d) result_q <= shifted;
      if (accept) begin
        data_q <= bus.operand;
        cnt_q  <= bus.shamt;
        op_q   <= op_dec;
        sign_q <= bus.operand[WIDTH-1];
      end else if (state_q == SHIFT) begin
        data_q <= shifted;
        cnt_q  <= cnt_q - s;
      end
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
